// File: rtl/mil_pkg.sv
// MIL-STD-1553 receive shared definitions.
// Timing constants are shared with the transmitter.
package mil_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC1,
    ST_SYNC2,
    ST_DATA,
    ST_DONE
  } rx_state_e;

  localparam int CLK_PER_BIT_DEF = 50;
  localparam int SYNC_TOL        = 10;
  localparam int RESYNC_WIN      = 5;

  function automatic int half_of(input int cpb);
    return cpb / 2;
  endfunction

  function automatic int sync_nom_of(input int cpb);
    return 3 * (cpb / 2);
  endfunction

  localparam int H        = half_of(CLK_PER_BIT_DEF);
  localparam int SYNC_NOM = 3 * H;
  localparam int SYNC_MIN = SYNC_NOM - SYNC_TOL;
  localparam int SYNC_MAX = SYNC_NOM + SYNC_TOL;

endpackage

// File: rtl/mil_rx_line.sv
// Two-flop synchronizers on RXP/RXN and
// decode of the line into +, - or idle.
module mil_rx_line (
  input  logic clk,
  input  logic rst_n,
  input  logic RXP,
  input  logic RXN,
  output logic level_p,
  output logic level_n,
  output logic level_idle
);

  logic [1:0] p_sync;
  logic [1:0] n_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_sync <= 2'b00;
      n_sync <= 2'b00;
    end else begin
      p_sync <= {p_sync[0], RXP};
      n_sync <= {n_sync[0], RXN};
    end
  end

  assign level_p    = p_sync[1] & ~n_sync[1];
  assign level_n    = ~p_sync[1] & n_sync[1];
  assign level_idle = ~(level_p | level_n);

endmodule

// File: rtl/mil_rxd.sv
// MIL-STD-1553 Manchester word receiver:
// sync detection, bit recovery with resync, parity.
module mil_rxd
  import mil_pkg::*;
#(
  parameter int CLK_PER_BIT = 50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RXP,
  input  logic        RXN,
  output logic [15:0] dat,
  output logic        CW_RX,
  output logic        DW_RX,
  output logic        ok_rx,
  output logic        err_rx,
  output logic        en_rx
);

  localparam int HB    = half_of(CLK_PER_BIT);
  localparam int S_NOM = sync_nom_of(CLK_PER_BIT);
  localparam int S_MIN = S_NOM - SYNC_TOL;
  localparam int S_MAX = S_NOM + SYNC_TOL;
  localparam int W     = $clog2(S_MAX + 2);

  localparam logic [W-1:0] T_S1   = W'(HB / 2);
  localparam logic [W-1:0] T_S2   = W'(HB + HB / 2);
  localparam logic [W-1:0] T_H    = W'(HB);
  localparam logic [W-1:0] T_RLO  = W'(HB - RESYNC_WIN);
  localparam logic [W-1:0] T_RHI  = W'(HB + RESYNC_WIN);
  localparam logic [W-1:0] T_LAST = W'(CLK_PER_BIT - 1);
  localparam logic [W-1:0] R_MIN  = W'(S_MIN);
  localparam logic [W-1:0] R_MAX  = W'(S_MAX);
  localparam logic [W-1:0] R_NOM1 = W'(S_NOM - 1);

  logic level_p;
  logic level_n;
  logic level_idle;

  mil_rx_line u_line (
    .clk        (clk),
    .rst_n      (rst_n),
    .RXP        (RXP),
    .RXN        (RXN),
    .level_p    (level_p),
    .level_n    (level_n),
    .level_idle (level_idle)
  );

  rx_state_e   state;
  logic [W-1:0] run;
  logic [W-1:0] btmr;
  logic [4:0]  bcnt;
  logic [15:0] dat_shift;
  logic        sync_cw;
  logic        first_p;
  logic        man_err;
  logic        par;
  logic        prev_p;
  logic        prev_n;

  logic opp;
  logic changed;
  logic in_win;
  logic at_smp;

  // opp: the level opposite to the first sync half
  assign opp     = sync_cw ? level_n : level_p;
  assign changed = (level_p & prev_n) | (level_n & prev_p);
  assign in_win  = (btmr >= T_RLO) && (btmr <= T_RHI);
  assign at_smp  = (btmr == T_S1) || (btmr == T_S2);
  assign en_rx   = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      run       <= '0;
      btmr      <= '0;
      bcnt      <= '0;
      dat_shift <= '0;
      sync_cw   <= 1'b0;
      first_p   <= 1'b0;
      man_err   <= 1'b0;
      par       <= 1'b0;
      prev_p    <= 1'b0;
      prev_n    <= 1'b0;
      dat       <= '0;
      CW_RX     <= 1'b0;
      DW_RX     <= 1'b0;
      ok_rx     <= 1'b0;
      err_rx    <= 1'b0;
    end else begin
      ok_rx  <= 1'b0;
      err_rx <= 1'b0;
      prev_p <= level_p;
      prev_n <= level_n;
      unique case (state)
        ST_IDLE: begin
          if (!level_idle) begin
            state   <= ST_SYNC1;
            run     <= '0;
            sync_cw <= level_p;
          end
        end
        ST_SYNC1: begin
          if (level_idle || run > R_MAX ||
              (opp && run < R_MIN)) begin
            state  <= ST_IDLE;
            err_rx <= 1'b1;
          end else if (opp) begin
            state <= ST_SYNC2;
            run   <= '0;
          end else begin
            run <= run + 1'b1;
          end
        end
        ST_SYNC2: begin
          if (level_idle || (!opp && run < R_MIN)) begin
            state  <= ST_IDLE;
            err_rx <= 1'b1;
          end else if (!opp || run == R_NOM1) begin
            state     <= ST_DATA;
            btmr      <= '0;
            bcnt      <= '0;
            man_err   <= 1'b0;
            par       <= 1'b0;
            dat_shift <= '0;
          end else begin
            run <= run + 1'b1;
          end
        end
        ST_DATA: begin
          if (level_idle && at_smp) begin
            state  <= ST_IDLE;
            err_rx <= 1'b1;
          end else begin
            if (btmr == T_S1) first_p <= level_p;
            if (btmr == T_S2) begin
              if (first_p == level_p) man_err <= 1'b1;
              par <= par ^ first_p;
              if (bcnt < 5'd16)
                dat_shift <= {dat_shift[14:0], first_p};
            end
            if (btmr == T_LAST) begin
              btmr <= '0;
              bcnt <= bcnt + 5'd1;
              if (bcnt == 5'd16) state <= ST_DONE;
            end else if (changed && in_win) begin
              btmr <= T_H;
            end else begin
              btmr <= btmr + 1'b1;
            end
          end
        end
        ST_DONE: begin
          dat   <= dat_shift;
          CW_RX <= sync_cw;
          DW_RX <= ~sync_cw;
          if (!man_err && par) ok_rx  <= 1'b1;
          else                 err_rx <= 1'b1;
          // next sync is timed from the nominal bit boundary
          if (level_idle) begin
            state <= ST_IDLE;
          end else begin
            state   <= ST_SYNC1;
            run     <= W'(1);
            sync_cw <= level_p;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mil_rxd.sv
// Directed bench for mil_rxd: drives Manchester
// words on RXP/RXN and checks strobes and data.
module tb_mil_rxd;

  logic        clk;
  logic        rst_n;
  logic        RXP;
  logic        RXN;
  logic [15:0] dat;
  logic        CW_RX;
  logic        DW_RX;
  logic        ok_rx;
  logic        err_rx;
  logic        en_rx;

  int n_chk;
  int n_err;
  int cyc;
  int ok_cnt;
  int err_cnt;
  int both_cnt;
  int last_ok;
  int prev_ok;
  int last_err;

  mil_rxd #(.CLK_PER_BIT(50)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .RXP    (RXP),
    .RXN    (RXN),
    .dat    (dat),
    .CW_RX  (CW_RX),
    .DW_RX  (DW_RX),
    .ok_rx  (ok_rx),
    .err_rx (err_rx),
    .en_rx  (en_rx)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    ok_cnt = 0; err_cnt = 0; both_cnt = 0;
    last_ok = 0; prev_ok = 0; last_err = 0;
  end

  always @(negedge clk) begin
    if (ok_rx) begin
      ok_cnt  <= ok_cnt + 1;
      prev_ok <= last_ok;
      last_ok <= cyc;
    end
    if (err_rx) begin
      err_cnt  <= err_cnt + 1;
      last_err <= cyc;
    end
    if (ok_rx && err_rx) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic hold(input logic p, input logic n,
                      input int cycles);
    RXP = p;
    RXN = n;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic send_word(input bit cmd,
                           input logic [15:0] d,
                           input bit pinv,
                           input int bad,
                           input int stop,
                           input int hl);
    logic [16:0] w;
    w = {d, ~(^d) ^ pinv};
    if (cmd) begin
      hold(1'b1, 1'b0, 3 * hl);
      hold(1'b0, 1'b1, 3 * hl);
    end else begin
      hold(1'b0, 1'b1, 3 * hl);
      hold(1'b1, 1'b0, 3 * hl);
    end
    for (int i = 0; i < 17; i++) begin
      if (i == stop) break;
      if (i == bad) begin
        hold(1'b1, 1'b0, 2 * hl);
      end else if (w[16 - i]) begin
        hold(1'b1, 1'b0, hl);
        hold(1'b0, 1'b1, hl);
      end else begin
        hold(1'b0, 1'b1, hl);
        hold(1'b1, 1'b0, hl);
      end
    end
    RXP = 1'b0;
    RXN = 1'b0;
  endtask

  int ok0;
  int err0;
  int t0;

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    RXP   = 1'b0;
    RXN   = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_dat", 32'(dat), 32'h0);
    chk("rst_cw", 32'(CW_RX), 32'h0);
    chk("rst_dw", 32'(DW_RX), 32'h0);
    chk("rst_ok", 32'(ok_rx), 32'h0);
    chk("rst_err", 32'(err_rx), 32'h0);
    chk("rst_en", 32'(en_rx), 32'h0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // command word A5C3
    ok0 = ok_cnt; err0 = err_cnt; t0 = cyc;
    send_word(1'b1, 16'hA5C3, 1'b0, 99, 99, 25);
    hold(1'b0, 1'b0, 100);
    chk("cw_ok", 32'(ok_cnt - ok0), 32'd1);
    chk("cw_err", 32'(err_cnt - err0), 32'd0);
    chk("cw_dat", 32'(dat), 32'hA5C3);
    chk("cw_cw", 32'(CW_RX), 32'h1);
    chk("cw_dw", 32'(DW_RX), 32'h0);
    chk("cw_lat",
        32'((last_ok - t0 >= 950) && (last_ok - t0 <= 1050)),
        32'h1);

    // two contiguous data words
    ok0 = ok_cnt; err0 = err_cnt;
    send_word(1'b0, 16'h0000, 1'b0, 99, 99, 25);
    send_word(1'b0, 16'hFFFF, 1'b0, 99, 99, 25);
    hold(1'b0, 1'b0, 100);
    chk("dw_ok", 32'(ok_cnt - ok0), 32'd2);
    chk("dw_err", 32'(err_cnt - err0), 32'd0);
    chk("dw_gap", 32'(last_ok - prev_ok), 32'd1000);
    chk("dw_dat", 32'(dat), 32'hFFFF);
    chk("dw_dw", 32'(DW_RX), 32'h1);
    chk("dw_cw", 32'(CW_RX), 32'h0);

    // short first sync half
    ok0 = ok_cnt; err0 = err_cnt;
    hold(1'b1, 1'b0, 60);
    hold(1'b0, 1'b1, 75);
    hold(1'b0, 1'b0, 200);
    chk("ss_ok", 32'(ok_cnt - ok0), 32'd0);
    chk("ss_err", 32'(err_cnt != err0), 32'h1);
    chk("ss_dat", 32'(dat), 32'hFFFF);
    chk("ss_en", 32'(en_rx), 32'h0);

    // parity inverted
    ok0 = ok_cnt; err0 = err_cnt;
    send_word(1'b1, 16'h1234, 1'b1, 99, 99, 25);
    hold(1'b0, 1'b0, 100);
    chk("par_ok", 32'(ok_cnt - ok0), 32'd0);
    chk("par_err", 32'(err_cnt - err0), 32'd1);
    chk("par_dat", 32'(dat), 32'h1234);

    // bit 5 sent as ++
    ok0 = ok_cnt; err0 = err_cnt;
    send_word(1'b0, 16'h5A5A, 1'b0, 5, 99, 25);
    hold(1'b0, 1'b0, 100);
    chk("man_ok", 32'(ok_cnt - ok0), 32'd0);
    chk("man_err", 32'(err_cnt - err0), 32'd1);
    chk("man_dat", 32'(dat), 32'h5E5A);
    chk("man_dw", 32'(DW_RX), 32'h1);

    // line idle after bit 8
    ok0 = ok_cnt; err0 = err_cnt;
    send_word(1'b1, 16'h0F0F, 1'b0, 99, 9, 25);
    t0 = cyc;
    hold(1'b0, 1'b0, 150);
    chk("idl_err", 32'(err_cnt - err0), 32'd1);
    chk("idl_ok", 32'(ok_cnt - ok0), 32'd0);
    chk("idl_time", 32'((last_err - t0) <= 55), 32'h1);
    chk("idl_dat", 32'(dat), 32'h5E5A);

    // bit period stretched by 4%
    ok0 = ok_cnt; err0 = err_cnt;
    send_word(1'b1, 16'h3C96, 1'b0, 99, 99, 26);
    hold(1'b0, 1'b0, 100);
    chk("slow_ok", 32'(ok_cnt - ok0), 32'd1);
    chk("slow_err", 32'(err_cnt - err0), 32'd0);
    chk("slow_dat", 32'(dat), 32'h3C96);
    chk("slow_cw", 32'(CW_RX), 32'h1);

    // reset during bit 10
    ok0 = ok_cnt; err0 = err_cnt;
    fork
      send_word(1'b1, 16'hBEEF, 1'b0, 99, 99, 25);
      begin
        repeat (660) @(negedge clk);
        chk("mid_en", 32'(en_rx), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mr_dat", 32'(dat), 32'h0);
        chk("mr_cw", 32'(CW_RX), 32'h0);
        chk("mr_ok", 32'(ok_rx), 32'h0);
        chk("mr_err", 32'(err_rx), 32'h0);
        chk("mr_en", 32'(en_rx), 32'h0);
      end
    join
    hold(1'b0, 1'b0, 20);
    rst_n = 1'b1;
    hold(1'b0, 1'b0, 20);
    chk("mr_nostb",
        32'((ok_cnt - ok0) + (err_cnt - err0)), 32'd0);
    send_word(1'b0, 16'h8001, 1'b0, 99, 99, 25);
    hold(1'b0, 1'b0, 100);
    chk("ar_ok", 32'(ok_cnt - ok0), 32'd1);
    chk("ar_err", 32'(err_cnt - err0), 32'd0);
    chk("ar_dat", 32'(dat), 32'h8001);
    chk("ar_dw", 32'(DW_RX), 32'h1);

    chk("excl", 32'(both_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mil_rxd.md
MIL_RXD -- requirements
Module: mil_rxd

Interface
REQ-001 Parameter CLK_PER_BIT, default 50, means clk cycles per 1 Mbit/s bit time (50 MHz clk); SHALL be even and at least 20.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 RXP  input  1  positive line from the transceiver, asynchronous to clk.
REQ-005 RXN  input  1  negative line from the transceiver, asynchronous to clk.
REQ-006 dat  output  16  last received data word, MSB first on the line, held until the next completed word.
REQ-007 CW_RX  output  1  last word had a command/status sync (+ then -).
REQ-008 DW_RX  output  1  last word had a data sync (- then +).
REQ-009 ok_rx  output  1  one-cycle strobe: word complete, Manchester valid, parity valid.
REQ-010 err_rx  output  1  one-cycle strobe: word aborted or completed with an error.
REQ-011 en_rx  output  1  high while the FSM is in any state other than IDLE.

Function
REQ-012 RXP and RXN SHALL each pass a 2-flop synchronizer; the decoded level is "+" when RXP=1 and RXN=0, "-" when RXP=0 and RXN=1, else "idle".
REQ-013 Constants: H=CLK_PER_BIT/2, SYNC_NOM=3H, SYNC_MIN=SYNC_NOM-10, SYNC_MAX=SYNC_NOM+10 (65/75/85 at the default).
REQ-014 FSM states: IDLE, SYNC1, SYNC2, DATA, DONE.
REQ-015 IDLE->SYNC1 on the first non-idle level; the run counter is cleared and the polarity is latched as the sync type.
REQ-016 SYNC1: the counter increments each cycle; a change to the opposite level with a run in SYNC_MIN..SYNC_MAX -> SYNC2, counter cleared.
REQ-017 SYNC1 abort: opposite level with a run below SYNC_MIN, run above SYNC_MAX, or idle -> IDLE, err_rx pulse.
REQ-018 SYNC2 -> DATA, bit counter = 0, bit timer = 0, at the first of:
- the run reaching SYNC_NOM with the level unchanged;
- a level change after a run of at least SYNC_MIN.
REQ-019 SYNC2 abort: a level change before SYNC_MIN, or idle -> IDLE, err_rx pulse.
REQ-020 DATA bit sampling: the bit timer counts 0..CLK_PER_BIT-1; first half sampled at timer H/2, second half at timer H+H/2.
REQ-021 DATA bit value: "+" then "-" = 1, "-" then "+" = 0; equal halves set a sticky Manchester-error flag.
REQ-022 Resync: a level change while the timer is in H-5..H+5 SHALL reload the timer to H; transitions elsewhere are ignored.
REQ-023 Bits 0..15 shift into dat_shift, MSB first; bit 16 is parity, odd over all 17 bits.
REQ-024 Idle level at any sample point in DATA -> IDLE, err_rx pulse, dat unchanged.
REQ-025 At the end of bit 16 (timer=CLK_PER_BIT-1) -> DONE for exactly one cycle.
REQ-026 DONE, word valid: dat, CW_RX and DW_RX update and ok_rx pulses.
REQ-027 DONE, word invalid: dat, CW_RX and DW_RX update and err_rx pulses.
REQ-028 ok_rx and err_rx SHALL never be high in the same cycle.
REQ-029 Contiguous words: DONE with a non-idle level SHALL enter SYNC1 with the run counter = 1, so the run is timed from the nominal bit boundary whether or not a transition occurs.
REQ-030 DONE with an idle level SHALL enter IDLE.
REQ-031 Exactly one of CW_RX and DW_RX SHALL be high after the first completed word.

Reset
REQ-032 rst_n low forces, asynchronously: state IDLE, all counters 0, synchronizers 0, dat=16'h0000, CW_RX=0, DW_RX=0, ok_rx=0, err_rx=0, en_rx=0.
REQ-033 Reset mid-word SHALL discard the partial word with no strobe; reception resumes at the next sync after release.

Structure
REQ-034 Package mil_pkg SHALL hold the FSM state enum, H, SYNC_MIN, SYNC_MAX and the resync window, shared with the transmitter.
REQ-035 Synchronizer plus level decode SHALL be one sub-module, mil_rx_line (outputs: level_p, level_n, level_idle).

Verification
REQ-036 Command sync, then 16'hA5C3 with correct odd parity -> ok_rx once at 20 us +/- 1 bit, dat=16'hA5C3, CW_RX=1, DW_RX=0.
REQ-037 Data sync, then 16'h0000 with parity 1, then a contiguous data word 16'hFFFF with parity 1 -> two ok_rx strobes exactly 1000 clk apart, DW_RX=1.
REQ-038 Sync first half of 60 clk -> err_rx, IDLE, no ok_rx, dat unchanged.
REQ-039 Valid word with the parity bit inverted -> err_rx at DONE, dat updated, ok_rx=0.
REQ-040 Bit 5 sent as "++" -> err_rx.
REQ-041 Line driven idle after bit 8 -> err_rx within one bit time.
REQ-042 Bit period stretched +4% for a full word -> ok_rx with correct dat.
REQ-043 rst_n pulsed low at bit 10 -> all outputs 0 immediately, no strobe, and the next word is received correctly.
